// File: rtl/apb_pkg.sv
// Shared types and constants for the APB byte-strobed memory slave.
// Imported by the FSM top and the storage array.
package apb_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, WAIT, ACCESS} apb_state_e;

   localparam logic APB_OKAY = 1'b0;
   localparam logic APB_ERR  = 1'b1;

   // Number of low address bits that select a byte within a data word.
   function automatic int byte_shift(input int data_w);
      return $clog2(data_w / 8);
   endfunction
endpackage

// File: rtl/apb_mem_array.sv
// Single-port word memory: byte-enable synchronous write, asynchronous read.
// Contents are never reset.
module apb_mem_array #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 64,
   parameter int IW     = 6
) (
   input  logic                  clk_i,
   input  logic                  we_i,
   input  logic [IW-1:0]         idx_i,
   input  logic [DATA_W/8-1:0]   strb_i,
   input  logic [DATA_W-1:0]     wdata_i,
   output logic [DATA_W-1:0]     rdata_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int i = 0; i < DATA_W / 8; i++) begin
            if (strb_i[i]) mem_q[idx_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
         end
      end
   end

   assign rdata_o = mem_q[idx_i];
endmodule

// File: rtl/apb_slave_mem.sv
// APB slave fronting a byte-strobed word memory with programmable wait states and error response.
// Responses are registered one cycle early so pready lands in transfer cycle WAIT_CYCLES+2.
module apb_slave_mem
   import apb_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int DEPTH       = 64,
   parameter int WAIT_CYCLES = 0
) (
   input  logic                  pclk,
   input  logic                  prst,
   input  logic [ADDR_W-1:0]     paddr,
   input  logic                  pwrite,
   input  logic                  psel,
   input  logic                  pen,
   input  logic [DATA_W-1:0]     pwdata,
   input  logic [DATA_W/8-1:0]   pstrb,
   output logic [DATA_W-1:0]     prdata,
   output logic                  pready,
   output logic                  pslverr
);
   localparam int SH = byte_shift(DATA_W);
   localparam int SW = DATA_W / 8;
   localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W-1:0] LOW_MASK = ADDR_W'((1 << SH) - 1);
   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 2);

   apb_state_e          state_q;
   logic [3:0]          cnt_q;
   logic [IW-1:0]       idx_q;
   logic                write_q, err_q;
   logic [DATA_W-1:0]   wdata_q;
   logic [SW-1:0]       strb_q;
   logic                pready_q, pslverr_q;
   logic [DATA_W-1:0]   prdata_q;

   logic [ADDR_W-1:0]   word_d;
   logic                err_d, setup_d, done_d, mem_we;
   logic [IW-1:0]       mem_idx;
   logic [DATA_W-1:0]   mem_rdata;

   assign word_d  = paddr >> SH;
   assign err_d   = ((paddr & LOW_MASK) != '0) || (32'(word_d) >= 32'(DEPTH));
   assign setup_d = psel && !pen;
   assign done_d  = (state_q == ACCESS) && psel && pen;
   assign mem_we  = done_d && write_q && !err_q && !prst;
   // The array is read at the setup edge when there are no wait states, so steer it to the live address then.
   assign mem_idx = ((state_q == IDLE) || ((state_q == ACCESS) && !pen)) ? word_d[IW-1:0] : idx_q;

   apb_mem_array #(.DATA_W(DATA_W), .DEPTH(DEPTH), .IW(IW)) u_mem (
      .clk_i   (pclk),
      .we_i    (mem_we),
      .idx_i   (mem_idx),
      .strb_i  (strb_q),
      .wdata_i (wdata_q),
      .rdata_o (mem_rdata)
   );

   always_ff @(posedge pclk) begin
      if (prst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
      end else begin
         pready_q  <= 1'b0;
         pslverr_q <= 1'b0;
         prdata_q  <= '0;
         case (state_q)
            IDLE, ACCESS: begin
               if (setup_d) begin
                  idx_q   <= word_d[IW-1:0];
                  write_q <= pwrite;
                  err_q   <= err_d;
                  wdata_q <= pwdata;
                  strb_q  <= pstrb;
                  if (WAIT_CYCLES == 0) begin
                     state_q   <= ACCESS;
                     pready_q  <= 1'b1;
                     pslverr_q <= err_d ? APB_ERR : APB_OKAY;
                     prdata_q  <= (err_d || pwrite) ? '0 : mem_rdata;
                  end else begin
                     state_q <= SETUP;
                  end
               end else begin
                  state_q <= IDLE;
               end
            end
            SETUP: begin
               if (!psel) begin
                  state_q <= IDLE;
               end else if (WAIT_CYCLES <= 1) begin
                  state_q   <= ACCESS;
                  pready_q  <= 1'b1;
                  pslverr_q <= err_q ? APB_ERR : APB_OKAY;
                  prdata_q  <= (err_q || write_q) ? '0 : mem_rdata;
               end else begin
                  state_q <= WAIT;
                  cnt_q   <= WAIT_LOAD;
               end
            end
            WAIT: begin
               if (!psel) begin
                  state_q <= IDLE;
               end else if (cnt_q == '0) begin
                  state_q   <= ACCESS;
                  pready_q  <= 1'b1;
                  pslverr_q <= err_q ? APB_ERR : APB_OKAY;
                  prdata_q  <= (err_q || write_q) ? '0 : mem_rdata;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign pready  = pready_q;
   assign pslverr = pslverr_q;
   assign prdata  = prdata_q;
endmodule

// File: tb/tb_apb_slave_mem.sv
// Bench for apb_slave_mem: one zero-wait 64-deep instance and one 3-wait 32-deep instance,
// driven by directed and random APB transfers against a word-array reference model.
module tb_apb_slave_mem;
   logic        pclk = 1'b0;
   logic        prst = 1'b1;
   logic [7:0]  paddr  [2];
   logic        pwrite [2];
   logic        psel   [2];
   logic        pen    [2];
   logic [31:0] pwdata [2];
   logic [3:0]  pstrb  [2];
   logic [31:0] prdata [2];
   logic        pready [2];
   logic        pslverr[2];

   int checks   = 0;
   int failures = 0;

   logic [31:0] mdl [2][64];
   int depth [2] = '{64, 32};
   int waits [2] = '{0, 3};

   always #5 pclk = ~pclk;

   apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)) u_dut0 (
      .pclk(pclk), .prst(prst), .paddr(paddr[0]), .pwrite(pwrite[0]), .psel(psel[0]),
      .pen(pen[0]), .pwdata(pwdata[0]), .pstrb(pstrb[0]), .prdata(prdata[0]),
      .pready(pready[0]), .pslverr(pslverr[0])
   );

   apb_slave_mem #(.ADDR_W(8), .DATA_W(32), .DEPTH(32), .WAIT_CYCLES(3)) u_dut1 (
      .pclk(pclk), .prst(prst), .paddr(paddr[1]), .pwrite(pwrite[1]), .psel(psel[1]),
      .pen(pen[1]), .pwdata(pwdata[1]), .pstrb(pstrb[1]), .prdata(prdata[1]),
      .pready(pready[1]), .pslverr(pslverr[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   // One complete transfer; paddr/pwdata/pstrb are scrambled during the access phase.
   task automatic xfer(input int d, input logic wr, input logic [7:0] addr,
                       input logic [31:0] wd, input logic [3:0] sb, output logic [31:0] rd);
      int   cyc;
      int   idx;
      logic exp_err;
      logic early_err;
      idx       = int'(addr) / 4;
      exp_err   = (int'(addr) % 4 != 0) || (idx >= depth[d]);
      early_err = 1'b0;
      @(negedge pclk);
      psel[d] = 1'b1; pen[d] = 1'b0; pwrite[d] = wr;
      paddr[d] = addr; pwdata[d] = wd; pstrb[d] = sb;
      @(negedge pclk);
      pen[d] = 1'b1;
      paddr[d] = 8'($urandom); pwdata[d] = $urandom; pstrb[d] = 4'($urandom);
      cyc = 2;
      while (!pready[d] && cyc < 40) begin
         if (pslverr[d]) early_err = 1'b1;
         @(negedge pclk);
         cyc++;
      end
      check("latency", 32'(cyc), 32'(waits[d] + 2));
      check("pslverr_early", 32'(early_err), 32'd0);
      check("pslverr", 32'(pslverr[d]), 32'(exp_err));
      rd = prdata[d];
      if (!wr) begin
         check("prdata", prdata[d], exp_err ? 32'd0 : mdl[d][idx]);
      end else if (!exp_err) begin
         for (int i = 0; i < 4; i++)
            if (sb[i]) mdl[d][idx][i*8 +: 8] = wd[i*8 +: 8];
      end
   endtask

   task automatic idle(input int d);
      @(negedge pclk);
      psel[d] = 1'b0; pen[d] = 1'b0;
      check("pready_one_cycle", 32'(pready[d]), 32'd0);
   endtask

   task automatic check_quiet(input string tag, input int d);
      check({tag, "_pready"},  32'(pready[d]),  32'd0);
      check({tag, "_pslverr"}, 32'(pslverr[d]), 32'd0);
      check({tag, "_prdata"},  prdata[d],       32'd0);
   endtask

   initial begin
      logic [31:0] rd;
      int          d, r, idx;
      logic [7:0]  a;
      for (int k = 0; k < 2; k++) begin
         psel[k] = 1'b0; pen[k] = 1'b0; pwrite[k] = 1'b0;
         paddr[k] = '0; pwdata[k] = '0; pstrb[k] = '0;
      end
      repeat (3) @(negedge pclk);
      check_quiet("reset0", 0);
      check_quiet("reset1", 1);
      prst = 1'b0;

      for (int k = 0; k < 2; k++)
         for (int i = 0; i < depth[k]; i++)
            xfer(k, 1'b1, 8'(i * 4), $urandom, 4'hF, rd);

      // Full write/readback and partial-strobe merge.
      xfer(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF, rd);
      xfer(0, 1'b0, 8'h04, 32'h0, 4'h0, rd);
      check("rd_deadbeef", rd, 32'hDEADBEEF);
      xfer(0, 1'b1, 8'h08, 32'h11223344, 4'hF, rd);
      idle(0);
      xfer(0, 1'b1, 8'h08, 32'hAABBCCDD, 4'b0101, rd);
      xfer(0, 1'b0, 8'h08, 32'h0, 4'h0, rd);
      check("rd_partial", rd, 32'h11BB33DD);

      // Misaligned read and out-of-range write (index 32 of a 32-deep array).
      xfer(0, 1'b0, 8'h02, 32'h0, 4'h0, rd);
      check("misaligned_rd", rd, 32'd0);
      xfer(1, 1'b1, 8'h80, 32'h5A5A5A5A, 4'hF, rd);
      xfer(1, 1'b0, 8'h00, 32'h0, 4'h0, rd);
      xfer(1, 1'b0, 8'h7C, 32'h0, 4'h0, rd);
      idle(1);

      // Abort during wait states: no write, slave ready for a normal transfer.
      @(negedge pclk);
      psel[1] = 1'b1; pen[1] = 1'b0; pwrite[1] = 1'b1;
      paddr[1] = 8'h0C; pwdata[1] = 32'h0BADF00D; pstrb[1] = 4'hF;
      @(negedge pclk); pen[1] = 1'b1;
      @(negedge pclk); psel[1] = 1'b0; pen[1] = 1'b0;
      @(negedge pclk);
      check_quiet("abort", 1);
      xfer(1, 1'b0, 8'h0C, 32'h0, 4'h0, rd);
      idle(1);

      // Access phase with no setup phase is ignored.
      @(negedge pclk);
      psel[0] = 1'b1; pen[0] = 1'b1; pwrite[0] = 1'b0; paddr[0] = 8'h04;
      repeat (4) begin
         @(negedge pclk);
         check("no_setup_pready", 32'(pready[0]), 32'd0);
      end
      idle(0);

      // Reset lands on the completing edge of a write: the write is dropped.
      @(negedge pclk);
      psel[0] = 1'b1; pen[0] = 1'b0; pwrite[0] = 1'b1;
      paddr[0] = 8'h10; pwdata[0] = 32'hCAFEF00D; pstrb[0] = 4'hF;
      @(negedge pclk);
      pen[0] = 1'b1;
      check("rst_pre_pready", 32'(pready[0]), 32'd1);
      prst = 1'b1;
      repeat (3) begin
         @(negedge pclk);
         check_quiet("midreset0", 0);
      end
      prst = 1'b0; psel[0] = 1'b0; pen[0] = 1'b0;
      xfer(0, 1'b0, 8'h10, 32'h0, 4'h0, rd);

      // Random traffic across both instances.
      for (int n = 0; n < 300; n++) begin
         d = $urandom_range(0, 1);
         r = $urandom_range(0, 9);
         idx = $urandom_range(0, depth[d] - 1);
         a = 8'(idx * 4);
         if (r == 7) a = 8'(idx * 4 + $urandom_range(1, 3));
         else if (r >= 8 && depth[d] < 64) a = 8'($urandom_range(depth[d], 63) * 4);
         xfer(d, 1'($urandom), a, $urandom, 4'($urandom), rd);
         if ($urandom_range(0, 9) < 3) idle(d);
      end
      idle(0);
      idle(1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/apb_slave_mem.md
# apb_slave_mem

Parametrised APB slave: a byte-strobed word memory with a configurable number of wait states and an error response. It is the successor to the 8-bit, zero-wait APB signal set: data width, depth and wait-state count are generalised, and PSTRB and PSLVERR are added. It sits behind the APB bus as the default memory-mapped target for driver/monitor benches and for SoC integration.

## Interface
Parameters:
- ADDR_W, 8: width of paddr (byte address).
- DATA_W, 32: data width; must be 8, 16, 32 or 64.
- DEPTH, 64: number of DATA_W words; must be ≤ 2^(ADDR_W − log2(DATA_W/8)).
- WAIT_CYCLES, 0: pready-low cycles inserted in each access phase; range 0..15.

Ports:
- pclk, input, 1: clock; all logic acts on the rising edge.
- prst, input, 1: reset, synchronous, active-high.
- paddr, input, ADDR_W: byte address.
- pwrite, input, 1: 1 = write, 0 = read.
- psel, input, 1: slave select.
- pen, input, 1: enable, which marks the access phase.
- pwdata, input, DATA_W: write data.
- pstrb, input, DATA_W/8: byte-lane write strobes.
- prdata, output, DATA_W: read data, valid while pready=1 on a read.
- pready, output, 1: transfer completes when psel & pen & pready.
- pslverr, output, 1: error response, valid while pready=1.

## Operation
- States: IDLE, SETUP, WAIT, ACCESS.
- IDLE → SETUP when psel=1 and pen=0.
  - On this edge, latch paddr, pwrite, pwdata and pstrb.
  - Compute err = (paddr low log2(DATA_W/8) bits ≠ 0) or (word index ≥ DEPTH).
  - Word index = paddr >> log2(DATA_W/8).
- SETUP (pen expected to be 1 in the next cycle):
  - WAIT_CYCLES = 0: go to ACCESS. pready, prdata and pslverr are registered, so they are valid in the first pen cycle.
  - WAIT_CYCLES > 0: go to WAIT and load the counter with WAIT_CYCLES − 1.
- WAIT: pready=0. The counter decrements each cycle; at 0, go to ACCESS with pready=1.
- ACCESS: pready=1, pslverr=err.
  - On a completing edge with a write and no error, each byte lane i with pstrb[i]=1 is written. Lanes with pstrb=0 are untouched.
  - Next state is IDLE. If psel=1 and pen=0 on that edge, go straight to SETUP instead (back-to-back transfers).
- Reads: prdata = mem[index], or 0 on error. It is driven only while pready=1 and is 0 otherwise.
- Errored writes do not modify memory.
- Abort: psel=0 in SETUP, WAIT or ACCESS → IDLE. No memory update; pready and pslverr are 0 next cycle.
- Protocol violations:
  - pen=1 while in IDLE (no setup phase) is ignored; the slave stays in IDLE.
  - Changing paddr or pwdata after setup is ignored, because the latched values are used.
- Memory contents are not reset.

## Timing
- Reset (prst=1 at an edge): state = IDLE, pready=0, pslverr=0, prdata=0, counter=0. Reset takes priority over any transfer in flight, including a write on the same edge.
- Latency from setup cycle to completing edge is WAIT_CYCLES + 2 cycles. With WAIT_CYCLES=0 this is the minimum APB transfer of 2 cycles.
- pready is high for exactly one cycle per transfer.
- pslverr is only ever 1 while pready=1.
- Read-after-write to the same address in back-to-back transfers returns the new data. The write commits at completion, before the next read's setup latch.

## Structure
- Package apb_pkg:
  - state enum apb_state_e (IDLE, SETUP, WAIT, ACCESS).
  - localparam function for the byte-shift width.
  - constants APB_OKAY=0 and APB_ERR=1.
- Sub-module apb_mem_array: single-port DATA_W × DEPTH array with a byte-enable write port and an asynchronous read. It is instantiated once, and the top module holds the FSM and the wait counter.

## Test plan
- Reset behaviour: assert prst for 3 cycles mid-transfer → pready=0, pslverr=0, prdata=0; the next transfer behaves normally.
- Write then read, DATA_W=32, WAIT_CYCLES=0:
  - write paddr=0x04, pwdata=0xDEADBEEF, pstrb=4'hF; then read 0x04 → prdata=0xDEADBEEF, pslverr=0.
  - pready high in the second cycle of each transfer.
- Partial strobe: write 0x08 with 0x11223344, then write 0x08 with 0xAABBCCDD and pstrb=4'b0101 → read returns 0x11BB33DD.
- Wait states, WAIT_CYCLES=3: any read → pready low for 3 pen cycles, high in the 4th; total transfer 5 cycles.
- Errors:
  - read paddr=0x02 (misaligned) → pslverr=1, prdata=0.
  - write to index 64 (paddr=0x100 requires ADDR_W≥9; use DEPTH=32, paddr=0x80) → pslverr=1 and memory unchanged on readback.
- Abort and violation:
  - drop psel during WAIT → no write occurs (readback shows the old value), and the slave is in IDLE next cycle.
  - pen=1 with no setup phase → pready stays 0.
